// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    JALR   = 2'd1,
    BRANCH = 2'd2,
    JAL    = 2'd3
  } pc_sel_t;

  // Bundles of the hazard-unit controls in and the decode-slot view out.
  typedef struct packed {
    logic            pc_enable;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jal_target;
    logic            ifde_en;
    logic            ifde_fl;
  } IF_i_t;

  typedef struct packed {
    logic [XLEN-1:0] de_pc;
    logic [XLEN-1:0] de_pc4;
    logic [XLEN-1:0] de_ir;
    logic            de_valid;
  } IF_o_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - keeps the fetched word across stalls and muxes the decode instruction
module fetch_hold_buffer
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_advance,
  input  logic             i_req_valid,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_ir
);

  logic [WIDTH-1:0] r_hold_ir;
  logic             r_hold_valid;

  // Capture only on the first stalled edge; later stall edges see memory garbage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_ir    <= NOP;
      r_hold_valid <= 1'b0;
    end else if (i_flush) begin
      r_hold_valid <= 1'b0;
    end else if (!i_advance) begin
      if (i_req_valid && !r_hold_valid) begin
        r_hold_ir    <= i_rdata;
        r_hold_valid <= 1'b1;
      end
    end else begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_ir = r_hold_valid ? r_hold_ir : (i_req_valid ? i_rdata : NOP);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, instruction-memory issue and decode-slot presentation
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_INSTR)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             pc_enable,
  input  logic [1:0]       if_pc_selection,
  input  logic [WIDTH-1:0] jalr_target,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jal_target,
  input  logic             IFDE_en,
  input  logic             IFDE_fl,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_rden,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] de_pc,
  output logic [WIDTH-1:0] de_pc4,
  output logic [WIDTH-1:0] de_ir,
  output logic             de_valid
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_req_pc;
  logic             r_req_valid;

  pc_sel_t          w_sel;
  logic [WIDTH-1:0] w_target_raw;
  logic [WIDTH-1:0] w_target;
  logic             w_redirect;
  logic             w_issue;

  assign w_sel = pc_sel_t'(if_pc_selection);

  always_comb begin
    w_target_raw = jal_target;
    case (w_sel)
      JALR:    w_target_raw = jalr_target;
      BRANCH:  w_target_raw = branch_target;
      default: w_target_raw = jal_target;
    endcase
  end

  // Bit 0 is always dropped; bit 1 misalignment is trapped elsewhere.
  assign w_target   = {w_target_raw[WIDTH-1:1], 1'b0};
  assign w_redirect = (w_sel != SEQ);
  assign w_issue    = pc_enable & IFDE_en & ~IFDE_fl & ~w_redirect;

  assign imem_rden = RST_N & w_issue;
  assign imem_addr = r_pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
    end else if (IFDE_fl) begin
      r_req_valid <= 1'b0;
      if (w_redirect) r_pc <= w_target;
    end else if (w_redirect) begin
      r_pc <= w_target;
      if (IFDE_en) r_req_valid <= 1'b0;
    end else if (IFDE_en) begin
      if (pc_enable) begin
        r_req_pc    <= r_pc;
        r_req_valid <= 1'b1;
        r_pc        <= r_pc + WIDTH'(4);
      end else begin
        r_req_valid <= 1'b0;
      end
    end
  end

  fetch_hold_buffer #(
    .WIDTH (WIDTH),
    .NOP   (NOP)
  ) u_hold (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_flush     (IFDE_fl),
    .i_advance   (IFDE_en),
    .i_req_valid (r_req_valid),
    .i_rdata     (imem_rdata),
    .o_ir        (de_ir)
  );

  assign de_valid = r_req_valid;
  assign de_pc    = r_req_pc;
  assign de_pc4   = r_req_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a slot-level reference model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        pc_enable;
  logic [1:0]  if_pc_selection;
  logic [31:0] jalr_target, branch_target, jal_target;
  logic        IFDE_en, IFDE_fl;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata;
  logic [31:0] de_pc, de_pc4, de_ir;
  logic        de_valid;

  fetch_stage dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .pc_enable       (pc_enable),
    .if_pc_selection (if_pc_selection),
    .jalr_target     (jalr_target),
    .branch_target   (branch_target),
    .jal_target      (jal_target),
    .IFDE_en         (IFDE_en),
    .IFDE_fl         (IFDE_fl),
    .imem_addr       (imem_addr),
    .imem_rden       (imem_rden),
    .imem_rdata      (imem_rdata),
    .de_pc           (de_pc),
    .de_pc4          (de_pc4),
    .de_ir           (de_ir),
    .de_valid        (de_valid)
  );

  always #5 CLK = ~CLK;

  // Memory returns the address as data; unread cycles present garbage.
  always @(posedge CLK) begin
    if (imem_rden) imem_rdata <= imem_addr;
    else           imem_rdata <= $urandom;
  end

  typedef struct {
    logic [31:0] addr;
    logic        rden;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: next PC and the decode slot as (valid, pc, word).
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_spc;
  logic [31:0] m_sir;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_spc   = 32'h0;
    m_sir   = NOP_W;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic pe, input logic [1:0] sel, input logic [31:0] tj,
                       input logic [31:0] tb, input logic [31:0] tl,
                       input logic en, input logic fl);
    exp_t        e;
    logic [31:0] tgt;
    pc_enable = pe; if_pc_selection = sel;
    jalr_target = tj; branch_target = tb; jal_target = tl;
    IFDE_en = en; IFDE_fl = fl;
    e.addr  = m_pc;
    e.rden  = pe && en && !fl && (sel == 2'd0);
    e.valid = m_valid;
    e.pc    = m_spc;
    e.pc4   = m_spc + 32'd4;
    e.ir    = m_valid ? m_sir : NOP_W;
    q.push_back(e);
    @(posedge CLK);
    tgt = (sel == 2'd1) ? tj : (sel == 2'd2) ? tb : tl;
    tgt[0] = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
      if (sel != 2'd0) m_pc = tgt;
    end else if (sel != 2'd0) begin
      m_pc = tgt;
      if (en) m_valid = 1'b0;
    end else if (en) begin
      if (pe) begin
        m_valid = 1'b1; m_spc = m_pc; m_sir = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic adv();
    cycle(1'b1, SEQ, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic stall();
    cycle(1'b1, SEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".imem_addr"}, imem_addr, 32'h0);
    check({tag, ".imem_rden"}, {31'h0, imem_rden}, 32'h0);
    check({tag, ".de_valid"}, {31'h0, de_valid}, 32'h0);
    check({tag, ".de_ir"}, de_ir, NOP_W);
    check({tag, ".de_pc"}, de_pc, 32'h0);
    check({tag, ".de_pc4"}, de_pc4, 32'h4);
  endtask

  exp_t got;
  always @(negedge CLK) begin
    #2;
    if (q.size() != 0) begin
      got = q.pop_front();
      check("imem_addr", imem_addr, got.addr);
      check("imem_rden", {31'h0, imem_rden}, {31'h0, got.rden});
      check("de_valid", {31'h0, de_valid}, {31'h0, got.valid});
      check("de_pc", de_pc, got.pc);
      check("de_pc4", de_pc4, got.pc4);
      check("de_ir", de_ir, got.ir);
    end
  end

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle($urandom_range(0, 99) >= 10, s, $urandom, $urandom, $urandom,
            $urandom_range(0, 99) >= 25, $urandom_range(0, 99) < 10);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    pc_enable = 1'b1; if_pc_selection = 2'd0;
    jalr_target = '0; branch_target = '0; jal_target = '0;
    IFDE_en = 1'b1; IFDE_fl = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    repeat (3) adv();
    repeat (3) stall();
    repeat (3) adv();
    cycle(1'b1, BRANCH, 32'h0, 32'h40, 32'h0, 1'b1, 1'b1);
    repeat (2) adv();
    cycle(1'b1, JALR, 32'h101, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) adv();
    cycle(1'b1, JAL, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    repeat (3) adv();
    adv(); stall();
    cycle(1'b1, SEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (2) adv();
    cycle(1'b1, JAL, 32'h0, 32'h0, 32'h200, 1'b0, 1'b0);
    repeat (2) adv();

    random_run(400);

    adv(); adv(); stall(); stall();
    #3;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) adv();
    random_run(200);

    #3;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/DE boundary and driven by the hazard unit's fetch controls (PC enable, PC-select, IF/DE enable and flush). It owns the program counter, issues reads to a synchronous instruction memory with one-cycle read latency, and presents the fetched instruction, its PC and a valid flag to decode. Its internal hold buffer keeps the fetched word intact across stalls, so decode never depends on the memory holding its output.

## Interface
- WIDTH, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP, 32'h0000_0013, word presented to decode when not valid (addi x0,x0,0)

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- pc_enable  in  1  permits sequential PC advance/issue
- if_pc_selection  in  2  pc_sel_t: 0 SEQ, 1 JALR, 2 BRANCH, 3 JAL
- jalr_target  in  WIDTH  redirect target for JALR
- branch_target  in  WIDTH  redirect target for BRANCH
- jal_target  in  WIDTH  redirect target for JAL
- IFDE_en  in  1  IF/DE advance enable (0 = stall)
- IFDE_fl  in  1  IF/DE flush (squash decode slot)
- imem_addr  out  WIDTH  read address, equals PC register
- imem_rden  out  1  read enable for this cycle's address
- imem_rdata  in  WIDTH  read data, valid the cycle after a read
- de_pc  out  WIDTH  PC of the instruction in the decode slot
- de_pc4  out  WIDTH  de_pc + 4
- de_ir  out  WIDTH  instruction in the decode slot, or NOP
- de_valid  out  1  decode slot holds a real instruction

## Operation
- State: pc, req_pc, req_valid, hold_ir, hold_valid.
- redirect = (if_pc_selection != SEQ). target = the selected target with bit 0 cleared.
- imem_rden = RST_N & pc_enable & IFDE_en & ~IFDE_fl & ~redirect. imem_addr = pc.
- Slot view, combinational:
  - de_valid = req_valid.
  - de_ir = hold_valid ? hold_ir : (req_valid ? imem_rdata : NOP).
  - de_pc = req_pc; de_pc4 = req_pc + 4.
- Edge priority, evaluated top-down:
  1. IFDE_fl: req_valid<=0, hold_valid<=0; pc<=target if redirect, else pc holds.
  2. redirect (no flush): pc<=target; no issue. Slot behaves as in the stall or advance case below, as selected by IFDE_en (advance with no issue leaves req_valid<=0).
  3. ~IFDE_en (stall): pc holds. If req_valid & ~hold_valid: hold_ir<=imem_rdata, hold_valid<=1.
  4. Advance, pc_enable=1: req_pc<=pc, req_valid<=1, hold_valid<=0, pc<=pc+4.
  5. Advance, pc_enable=0: req_valid<=0, hold_valid<=0, pc holds.
- Arithmetic: pc+4 and req_pc+4 are modulo 2^WIDTH, so 32'hFFFF_FFFC wraps to 0. Bit 1 of a target passes through unchecked; misalignment traps are handled elsewhere.

## Timing
- Reset (RST_N low, asynchronous): pc=RESET_PC, req_pc=RESET_PC, req_valid=0, hold_valid=0, hold_ir=NOP.
  - Outputs during reset: imem_addr=RESET_PC, imem_rden=0, de_valid=0, de_ir=NOP, de_pc=RESET_PC, de_pc4=RESET_PC+4.
- First issue on the first edge after RST_N rises, with pc_enable=1 and IFDE_en=1. That instruction appears at decode one cycle later.
- Issue-to-decode latency 1 cycle; throughput 1 instruction/cycle with no stalls.
- Redirect at edge t: target issued at edge t+1, visible at decode after t+1. Penalty is the redirect cycle plus whatever the hazard unit flushes.
- A multi-cycle stall keeps de_ir/de_pc stable; the hold buffer captures only on the first stalled edge. Release resumes with no lost or duplicated instruction.
- Flush during a stall: the flush wins, hold_valid clears and the slot becomes NOP.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, without waiting for an edge.

## Structure
- pipeline_structs_defs.svh gets:
  - pc_sel_t enum (SEQ/JALR/BRANCH/JAL)
  - NOP_INSTR constant
  - IF_i_t / IF_o_t structs bundling the inputs and outputs above, matching HU_i_t/HU_o_t style
- One sub-module: fetch_hold_buffer (hold_ir/hold_valid plus the de_ir mux). The PC and next-PC logic stays in fetch_stage.

## Test plan
- Reset release, memory returns addr as data, IFDE_en=1, pc_enable=1:
  - imem_addr 0,4,8,… each cycle.
  - de_ir=0,4,8 one cycle behind.
  - de_valid rises one cycle after release.
- Stall 3 cycles while de_pc=8, with memory driving garbage during the stall:
  - de_ir stays 8's word; imem_rden=0; pc stays 12.
  - After release, de_pc sequence is 12, 16.
- if_pc_selection=BRANCH, branch_target=0x40, simultaneous IFDE_fl=1:
  - Next cycle de_valid=0, de_ir=NOP, imem_addr=0x40.
  - The cycle after, de_pc=0x40.
- JALR with jalr_target=0x101: imem_addr becomes 0x100.
- pc=32'hFFFF_FFFC, advance: imem_addr becomes 0; de_pc4 for that instruction is 0.
- Assert RST_N low asynchronously mid-stall with hold_valid=1: outputs immediately match the reset values, with no clock edge required.
